// File: rtl/countdown_mm_ss_pkg.sv
// Shared definitions for the mm:ss countdown timer: digit widths, digit limits,
// controller states and the packed BCD time value.
package countdown_mm_ss_pkg;

  localparam int MIN10_W = 3;
  localparam int MIN1_W  = 4;
  localparam int SEC10_W = 3;
  localparam int SEC1_W  = 4;

  localparam int DIGIT9_LIMIT = 9;
  localparam int DIGIT5_LIMIT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [MIN10_W-1:0] m10;
    logic [MIN1_W-1:0]  m1;
    logic [SEC10_W-1:0] s10;
    logic [SEC1_W-1:0]  s1;
  } bcd_time_t;

  function automatic logic time_ok(input bcd_time_t t);
    return (t.m10 <= MIN10_W'(DIGIT5_LIMIT)) && (t.m1 <= MIN1_W'(DIGIT9_LIMIT)) &&
           (t.s10 <= SEC10_W'(DIGIT5_LIMIT)) && (t.s1 <= SEC1_W'(DIGIT9_LIMIT));
  endfunction

endpackage

// File: rtl/countdown_mm_ss_digit.sv
// One BCD down-counting digit: wraps 0 -> LIMIT and reports a borrow to the
// next more-significant digit in the same cycle it is enabled at zero.
module bcd_down_digit #(
  parameter int W     = 4,
  parameter int LIMIT = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] digit,
  output logic         borrow_out
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] r_digit;

  always_ff @(posedge clk) begin
    if (rst)
      r_digit <= '0;
    else if (load)
      r_digit <= load_val;
    else if (en)
      r_digit <= (r_digit == '0) ? LIM : r_digit - W'(1);
  end

  assign digit      = r_digit;
  assign borrow_out = en & (r_digit == '0);

endmodule

// File: rtl/countdown_mm_ss.sv
// mm:ss countdown timer: four chained BCD digits driven by an IDLE/RUN/PAUSE/DONE
// controller with load validation, expiry pulse and optional auto-reload.
module countdown_mm_ss
  import countdown_mm_ss_pkg::*;
#(
  parameter int AUTO_RELOAD = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               load,
  input  logic [MIN10_W-1:0] load_min_10,
  input  logic [MIN1_W-1:0]  load_min_1,
  input  logic [SEC10_W-1:0] load_sec_10,
  input  logic [SEC1_W-1:0]  load_sec_1,
  input  logic               start,
  input  logic               pause,
  output logic [MIN10_W-1:0] minutes_10,
  output logic [MIN1_W-1:0]  minutes_1,
  output logic [SEC10_W-1:0] seconds_10,
  output logic [SEC1_W-1:0]  seconds_1,
  output logic               running,
  output logic               done,
  output logic               load_err,
  output state_t             dbg_state
);

  localparam bcd_time_t ONE_SEC = bcd_time_t'(1);

  state_t    r_state;
  logic      r_running;
  logic      r_done;
  logic      r_load_err;
  bcd_time_t r_reload;
  logic      r_reload_pending;

  bcd_time_t w_cur;
  bcd_time_t w_load_val;
  bcd_time_t w_ld_val;
  logic      w_load_ok;
  logic      w_dec;
  logic      w_ld;
  logic      w_at_one;
  logic      w_is_zero;
  logic      w_b0, w_b1, w_b2, w_unused_borrow;

  assign w_load_val = '{m10: load_min_10, m1: load_min_1, s10: load_sec_10, s1: load_sec_1};
  assign w_load_ok  = load && (r_state != ST_RUN) && time_ok(w_load_val);
  // The cycle after an auto-reload expiry is spent restoring the preset; ticks then are dropped.
  assign w_dec      = (r_state == ST_RUN) && tick && !pause && !r_reload_pending;
  assign w_ld       = w_load_ok || r_reload_pending;
  assign w_ld_val   = r_reload_pending ? r_reload : w_load_val;
  assign w_at_one   = (w_cur == ONE_SEC);
  assign w_is_zero  = (w_cur == '0);

  bcd_down_digit #(.W(SEC1_W), .LIMIT(DIGIT9_LIMIT)) u_sec1 (
    .clk(clk), .rst(rst), .en(w_dec), .load(w_ld), .load_val(w_ld_val.s1),
    .digit(w_cur.s1), .borrow_out(w_b0));

  bcd_down_digit #(.W(SEC10_W), .LIMIT(DIGIT5_LIMIT)) u_sec10 (
    .clk(clk), .rst(rst), .en(w_b0), .load(w_ld), .load_val(w_ld_val.s10),
    .digit(w_cur.s10), .borrow_out(w_b1));

  bcd_down_digit #(.W(MIN1_W), .LIMIT(DIGIT9_LIMIT)) u_min1 (
    .clk(clk), .rst(rst), .en(w_b1), .load(w_ld), .load_val(w_ld_val.m1),
    .digit(w_cur.m1), .borrow_out(w_b2));

  bcd_down_digit #(.W(MIN10_W), .LIMIT(DIGIT5_LIMIT)) u_min10 (
    .clk(clk), .rst(rst), .en(w_b2), .load(w_ld), .load_val(w_ld_val.m10),
    .digit(w_cur.m10), .borrow_out(w_unused_borrow));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_running        <= 1'b0;
      r_done           <= 1'b0;
      r_load_err       <= 1'b0;
      r_reload         <= '0;
      r_reload_pending <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (r_reload_pending) begin
            r_reload_pending <= 1'b0;
          end else if (pause) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end else if (tick && w_at_one) begin
            r_done <= 1'b1;
            if (AUTO_RELOAD != 0 && r_reload != '0) begin
              r_reload_pending <= 1'b1;
            end else begin
              r_state   <= ST_DONE;
              r_running <= 1'b0;
            end
          end
        end
        default: begin
          // Load outranks start: a start issued alongside any load is dropped.
          if (load) begin
            if (w_load_ok) r_reload   <= w_load_val;
            else           r_load_err <= 1'b1;
          end else if (start) begin
            if (w_is_zero) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign minutes_10 = w_cur.m10;
  assign minutes_1  = w_cur.m1;
  assign seconds_10 = w_cur.s10;
  assign seconds_1  = w_cur.s1;
  assign running    = r_running;
  assign done       = r_done;
  assign load_err   = r_load_err;
  assign dbg_state  = r_state;

endmodule
